decoder_nx_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder, successor to the team's combinational 2:4 decoder.
- Adds a valid/ready input handshake and a registered, held output.
- Adds a SCAN mode that walks a single active line across all outputs with programmable dwell.
- Used as a select/strobe generator for banked peripherals and test sequencing.

---
 rtl/decoder_nx_seq.sv | 106 ++++++++++
 tb/tb_decoder_nx_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/decoder_nx_seq.sv
// Registered N-to-2^N one-hot decoder with a valid/ready input, held output and a SCAN walk.
// Optional input parity check is enabled by defining DECODER_PARITY_EN (adds in_par, par_err).
module decoder_nx_seq #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              scan_mode,
  input  logic              in_valid,
  input  logic [N-1:0]      in_sel,
`ifdef DECODER_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic              in_ready,
  output logic [2**N-1:0]   y,
  output logic              y_valid,
  output logic              scan_wrap
);

  localparam int OUTS = 2**N;
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST = '1;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  idx;
  logic          accept;
  logic          par_ok;

  assign in_ready = en & ~scan_mode;
  assign accept   = in_valid & in_ready;

`ifdef DECODER_PARITY_EN
  assign par_ok = (in_par == ^in_sel);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      scan_wrap <= 1'b0;
`ifdef DECODER_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      scan_wrap <= 1'b0;
`ifdef DECODER_PARITY_EN
      par_err   <= 1'b0;
`endif
      if (!en) begin
        state   <= IDLE;
        cnt     <= '0;
        idx     <= '0;
        y       <= '0;
        y_valid <= 1'b0;
      end else if (scan_mode) begin
        if (state != SCAN) begin
          // Entry lights y[0] immediately; the first dwell count happens on this cycle.
          state   <= SCAN;
          cnt     <= '0;
          idx     <= '0;
          y       <= OUTS'(1);
          y_valid <= 1'b1;
        end else if (cnt == CNT_LAST) begin
          cnt       <= '0;
          idx       <= idx + 1'b1;
          y         <= OUTS'(1) << (idx + 1'b1);
          scan_wrap <= (idx == IDX_LAST);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (state == SCAN) begin
        state   <= IDLE;
        cnt     <= '0;
        idx     <= '0;
        y       <= '0;
        y_valid <= 1'b0;
      end else if (accept) begin
        if (par_ok) begin
          state   <= HOLD;
          y       <= OUTS'(1) << in_sel;
          y_valid <= 1'b1;
        end else begin
          state   <= IDLE;
          y       <= '0;
          y_valid <= 1'b0;
`ifdef DECODER_PARITY_EN
          par_err <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Directed bench for decoder_nx_seq (N=3, DWELL=2) with a queue-based expected-output scoreboard.
module tb_decoder_nx_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, scan_mode, in_valid;
  logic [2:0] in_sel;
  logic       in_ready;
  logic [7:0] y;
  logic       y_valid, scan_wrap;
  logic       par_bad;
`ifdef DECODER_PARITY_EN
  logic       in_par, par_err;
  assign in_par = (^in_sel) ^ par_bad;
`endif

  typedef struct packed {
    logic [7:0] y;
    logic       v;
    logic       w;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder_nx_seq #(.N(3), .DWELL(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .scan_mode (scan_mode),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
`ifdef DECODER_PARITY_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .in_ready  (in_ready),
    .y         (y),
    .y_valid   (y_valid),
    .scan_wrap (scan_wrap)
  );

  task automatic chk1(input string tag, input logic obs, input logic req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, req);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  // Push the expectation for the coming edge, clock once, then pop and compare.
  task automatic cyc(input string tag, input logic [7:0] ey, input logic ev,
                     input logic ew, input logic ep);
    exp_t e;
    sb.push_back('{y: ey, v: ev, w: ew, p: ep});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk8({tag, ".y"}, y, e.y);
    chk1({tag, ".y_valid"}, y_valid, e.v);
    chk1({tag, ".scan_wrap"}, scan_wrap, e.w);
`ifdef DECODER_PARITY_EN
    chk1({tag, ".par_err"}, par_err, e.p);
`endif
  endtask

  initial begin
    logic [7:0] oh;
    rst_n = 1'b0; en = 1'b0; scan_mode = 1'b0; in_valid = 1'b0; in_sel = '0; par_bad = 1'b0;
    #22;
    chk8("reset.y", y, 8'h00);
    chk1("reset.y_valid", y_valid, 1'b0);
    chk1("reset.scan_wrap", scan_wrap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DIRECT decode, back-to-back accepts
    en = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_sel = 3'(k);
      #1;
      chk1("direct.in_ready", in_ready, 1'b1);
      oh = 8'h01 << k;
      cyc("direct", oh, 1'b1, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    cyc("hold", 8'h80, 1'b1, 1'b0, 1'b0);
    cyc("hold", 8'h80, 1'b1, 1'b0, 1'b0);

    // Enable drop from HOLD
    in_valid = 1'b1; in_sel = 3'd4;
    cyc("load4", 8'h10, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0; en = 1'b0;
    #1;
    chk1("endrop.in_ready", in_ready, 1'b0);
    cyc("endrop", 8'h00, 1'b0, 1'b0, 1'b0);
    en = 1'b1; in_valid = 1'b1; in_sel = 3'd2;
    cyc("reen", 8'h04, 1'b1, 1'b0, 1'b0);

    // Priority: scan_mode beats a valid code
    scan_mode = 1'b1; in_sel = 3'd6;
    #1;
    chk1("prio.in_ready", in_ready, 1'b0);
    cyc("prio", 8'h01, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0; scan_mode = 1'b0;
    cyc("scan_exit", 8'h00, 1'b0, 1'b0, 1'b0);

    // SCAN walk from IDLE: each line for 2 cycles, wrap pulse 16 cycles after first y[0]
    scan_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      cyc("walk", oh, 1'b1, 1'b0, 1'b0);
      cyc("walk", oh, 1'b1, 1'b0, 1'b0);
    end
    cyc("wrap", 8'h01, 1'b1, 1'b1, 1'b0);
    cyc("postwrap", 8'h01, 1'b1, 1'b0, 1'b0);
    cyc("postwrap", 8'h02, 1'b1, 1'b0, 1'b0);

    // Async reset mid-scan at index 5
    scan_mode = 1'b0;
    cyc("idle", 8'h00, 1'b0, 1'b0, 1'b0);
    scan_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      oh = 8'h01 << i;
      cyc("rescan", oh, 1'b1, 1'b0, 1'b0);
      cyc("rescan", oh, 1'b1, 1'b0, 1'b0);
    end
    cyc("rescan5", 8'h20, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("arst.y", y, 8'h00);
    chk1("arst.y_valid", y_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("arst_entry", 8'h01, 1'b1, 1'b0, 1'b0);
    cyc("arst_entry", 8'h01, 1'b1, 1'b0, 1'b0);
    cyc("arst_entry", 8'h02, 1'b1, 1'b0, 1'b0);

`ifdef DECODER_PARITY_EN
    scan_mode = 1'b0;
    cyc("par_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_sel = 3'b011; par_bad = 1'b1;
    cyc("par_bad", 8'h00, 1'b0, 1'b0, 1'b1);
    par_bad = 1'b0;
    cyc("par_good", 8'h08, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    cyc("par_hold", 8'h08, 1'b1, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
